// File: rtl/adc_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : adc_scan_scheduler
// Purpose  : Paces SPI ADC frames, selects each frame's channel (host request
//            first, else round-robin) and stores pipeline-corrected results.
// Revision : 1.0
// ============================================================================
module adc_scan_scheduler #(
   parameter int CH_W     = 3,
   parameter int DATA_W   = 12,
   parameter int RATE_DIV = 50000,
   parameter int TIMEOUT  = 2000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [(1<<CH_W)-1:0]       ch_en_i,
   input  logic                       host_req_i,
   input  logic [CH_W-1:0]            host_ch_i,
   output logic                       host_ack_o,
   output logic                       frm_start_o,
   output logic [CH_W-1:0]            frm_addr_o,
   input  logic                       frm_busy_i,
   input  logic                       frm_done_i,
   input  logic [DATA_W-1:0]          frm_data_i,
   output logic [(1<<CH_W)*8-1:0]     res_data_o,
   output logic [(1<<CH_W)-1:0]       res_valid_o,
   output logic                       upd_stb_o,
   output logic [CH_W-1:0]            upd_ch_o,
   output logic                       err_timeout_o
);

   localparam int NUM_CH = 1 << CH_W;
   localparam int CNT_W  = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
   localparam int WD_W   = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_STORE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    tick_cnt_q;
   logic                tick_pend_q, tick_pend_d;
   logic [CH_W-1:0]     frm_addr_q, frm_addr_d;
   logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [7:0]          data_q, data_d;
   logic [CH_W-1:0]     prev_addr_q, prev_addr_d;
   logic                prev_valid_q, prev_valid_d;
   logic [7:0]          res_q [NUM_CH];
   logic [NUM_CH-1:0]   res_valid_q;

   logic                tick;
   logic                tick_clr;
   logic                rr_hit;
   logic [CH_W-1:0]     rr_sel;
   logic [CH_W-1:0]     cand;
   logic                host_ack;
   logic                upd_stb;
   logic                err_timeout;

   assign tick = (tick_cnt_q == CNT_W'(RATE_DIV - 1));

   // A tick arriving in the same cycle IDLE consumes the old one stays pending.
   assign tick_pend_d = tick | (tick_pend_q & ~tick_clr);

   always_comb begin
      rr_hit = 1'b0;
      rr_sel = '0;
      cand   = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand = rr_ptr_q + CH_W'(i);
         if (!rr_hit && ch_en_i[cand]) begin
            rr_hit = 1'b1;
            rr_sel = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      tick_clr     = 1'b0;
      frm_addr_d   = frm_addr_q;
      rr_ptr_d     = rr_ptr_q;
      wd_d         = wd_q;
      data_d       = data_q;
      prev_addr_d  = prev_addr_q;
      prev_valid_d = prev_valid_q;
      host_ack     = 1'b0;
      upd_stb      = 1'b0;
      err_timeout  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tick_pend_q && !frm_busy_i) begin
               tick_clr = 1'b1;
               if (host_req_i) begin
                  frm_addr_d = host_ch_i;
                  host_ack   = 1'b1;
                  state_d    = S_ISSUE;
               end else if (rr_hit) begin
                  frm_addr_d = rr_sel;
                  rr_ptr_d   = rr_sel;
                  state_d    = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (frm_done_i) begin
               data_d  = frm_data_i[DATA_W-1 -: 8];
               state_d = S_STORE;
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               err_timeout  = 1'b1;
               prev_valid_d = 1'b0;
               state_d      = S_IDLE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_STORE: begin
            // The sample just returned belongs to the address of the previous frame.
            upd_stb      = prev_valid_q;
            prev_addr_d  = frm_addr_q;
            prev_valid_d = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         tick_cnt_q   <= '0;
         tick_pend_q  <= 1'b0;
         frm_addr_q   <= '0;
         rr_ptr_q     <= CH_W'(NUM_CH - 1);
         wd_q         <= '0;
         data_q       <= '0;
         prev_addr_q  <= '0;
         prev_valid_q <= 1'b0;
         res_valid_q  <= '0;
         for (int i = 0; i < NUM_CH; i++) res_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         tick_cnt_q   <= tick ? '0 : tick_cnt_q + CNT_W'(1);
         tick_pend_q  <= tick_pend_d;
         frm_addr_q   <= frm_addr_d;
         rr_ptr_q     <= rr_ptr_d;
         wd_q         <= wd_d;
         data_q       <= data_d;
         prev_addr_q  <= prev_addr_d;
         prev_valid_q <= prev_valid_d;
         if (upd_stb) begin
            res_q[prev_addr_q]       <= data_q;
            res_valid_q[prev_addr_q] <= 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_res
         assign res_data_o[8*gi +: 8] = res_q[gi];
      end
      if (DATA_W > 8) begin : g_lsb
         logic unused_lsb;
         assign unused_lsb = ^frm_data_i[DATA_W-9:0];
      end
   endgenerate

   assign host_ack_o    = host_ack;
   assign frm_start_o   = (state_q == S_ISSUE);
   assign frm_addr_o    = frm_addr_q;
   assign res_valid_o   = res_valid_q;
   assign upd_stb_o     = upd_stb;
   assign upd_ch_o      = upd_stb ? prev_addr_q : '0;
   assign err_timeout_o = err_timeout;

endmodule
`default_nettype wire
